// File: rtl/cardinal_nic_pkg.sv
// Shared constants, types and status-word helper for the cardinal NIC.
// Optional feature macro used by the NIC: NIC_ERR_STATUS_EN.
package cardinal_nic_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 2;

    localparam int VC_BIT   = 0;
    localparam int FULL_BIT = 63;
    localparam int ERR_BIT  = 62;

    typedef enum logic [ADDR_WIDTH-1:0] {
        NIC_IN_BUF   = 2'b00,
        NIC_IN_STAT  = 2'b01,
        NIC_OUT_BUF  = 2'b10,
        NIC_OUT_STAT = 2'b11
    } nic_addr_e;

    // Words are big-endian numbered: bit 0 is the MSB, bit 63 the LSB.
    typedef logic [0:DATA_WIDTH-1] word_t;

    function automatic word_t make_status(input logic full, input logic err);
        word_t w;
        w           = '0;
        w[FULL_BIT] = full;
        w[ERR_BIT]  = err;
        return w;
    endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// Processor load/store bus and router local-port handshake of the cardinal NIC.
// master = processor + router side, slave = NIC.
interface cardinal_nic_if;
    import cardinal_nic_pkg::*;

    logic [0:ADDR_WIDTH-1] addr;
    word_t                 d_in;
    word_t                 d_out;
    logic                  nicEn;
    logic                  nicWrEn;

    logic                  net_si;
    logic                  net_ri;
    word_t                 net_di;
    logic                  net_so;
    logic                  net_ro;
    word_t                 net_do;
    logic                  net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

endinterface

// File: rtl/cardinal_nic_channel_buf.sv
// One-entry channel buffer with full flag; load wins over clear (they are
// mutually exclusive in use, since load needs empty and clear needs full).
module nic_channel_buf
    import cardinal_nic_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  clear,
    input  word_t d,
    output word_t q,
    output logic  full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC top: input/output channel buffers, register map, router handshake.
// Define NIC_ERR_STATUS_EN to add sticky error flags at status bit 62.
module cardinal_nic
    import cardinal_nic_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    cardinal_nic_if.slave  nic
);

    word_t     in_buf;
    word_t     out_buf;
    logic      in_full;
    logic      out_full;
    logic      in_err;
    logic      out_err;
    logic      rd;
    logic      wr;
    nic_addr_e sel;

    assign sel = nic_addr_e'(nic.addr);
    assign rd  = nic.nicEn & ~nic.nicWrEn;
    assign wr  = nic.nicEn &  nic.nicWrEn;

    assign nic.net_ri = ~in_full;
    assign nic.net_so = out_full & nic.net_ro & (out_buf[VC_BIT] == nic.net_polarity);
    assign nic.net_do = out_buf;

    nic_channel_buf u_in_buf (
        .clk   (clk),
        .reset (reset),
        .load  (nic.net_si & ~in_full),
        .clear (rd && (sel == NIC_IN_BUF) && in_full),
        .d     (nic.net_di),
        .q     (in_buf),
        .full  (in_full)
    );

    // A store into a full output buffer is dropped even if it drains this cycle.
    nic_channel_buf u_out_buf (
        .clk   (clk),
        .reset (reset),
        .load  (wr && (sel == NIC_OUT_BUF) && !out_full),
        .clear (nic.net_so),
        .d     (nic.d_in),
        .q     (out_buf),
        .full  (out_full)
    );

`ifdef NIC_ERR_STATUS_EN
    // Sticky flags; a status read returns the set value and clears it at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_err  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (rd && (sel == NIC_IN_BUF) && !in_full)
                in_err <= 1'b1;
            else if (rd && (sel == NIC_IN_STAT))
                in_err <= 1'b0;
            if (wr && (sel == NIC_OUT_BUF) && out_full)
                out_err <= 1'b1;
            else if (rd && (sel == NIC_OUT_STAT))
                out_err <= 1'b0;
        end
    end
`else
    assign in_err  = 1'b0;
    assign out_err = 1'b0;
`endif

    always_comb begin
        nic.d_out = '0;
        case (sel)
            NIC_IN_BUF:   nic.d_out = in_buf;
            NIC_IN_STAT:  nic.d_out = make_status(in_full, in_err);
            NIC_OUT_BUF:  nic.d_out = '0;
            NIC_OUT_STAT: nic.d_out = make_status(out_full, out_err);
            default:      nic.d_out = '0;
        endcase
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic; expectations adapt to
// NIC_ERR_STATUS_EN when that macro is defined.
module tb_cardinal_nic;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cardinal_nic_if bus ();

    cardinal_nic dut (
        .clk   (clk),
        .reset (reset),
        .nic   (bus.slave)
    );

    localparam logic [0:63] ST_FULL = 64'h1;
`ifdef NIC_ERR_STATUS_EN
    localparam logic [0:63] ST_ERR  = 64'h2;
`else
    localparam logic [0:63] ST_ERR  = 64'h0;
`endif

    localparam logic [0:63] P1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [0:63] P2 = 64'h1111_2222_3333_4444;
    localparam logic [0:63] P3 = 64'h5555_6666_7777_8888;
    localparam logic [0:63] P4 = 64'h8000_0000_0000_0055;
    localparam logic [0:63] P5 = 64'h0000_0000_0000_00AA;
    localparam logic [0:63] P6 = 64'h0000_0000_0000_0BAD;
    localparam logic [0:63] P7 = 64'hCAFE_F00D_DEAD_BEEF;
    localparam logic [0:63] P8 = 64'h8123_0000_0000_0077;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [0:63] observed,
                               input logic [0:63] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic en, input logic we,
                                 input logic [0:63] d);
        bus.addr    = a;
        bus.nicEn   = en;
        bus.nicWrEn = we;
        bus.d_in    = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 1'b0, 1'b0, 64'h0);
    endtask

    // Side-effect-free peek of a register through the combinational load path.
    task automatic peek(input string tag, input logic [1:0] a, input logic [0:63] expected);
        applyStimulus(a, 1'b0, 1'b0, 64'h0);
        #1;
        checkOutput(tag, bus.d_out, expected);
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b0;
        bus.net_si       = 1'b0;
        bus.net_di       = '0;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        checkOutput("rst_ri", 64'(bus.net_ri), 64'd1);
        checkOutput("rst_so", 64'(bus.net_so), 64'd0);
        checkOutput("rst_do", bus.net_do, 64'h0);
        peek("rst_stat01", 2'b01, 64'h0);
        peek("rst_stat11", 2'b11, 64'h0);

        // Router -> processor
        bus.net_si = 1'b1;
        bus.net_di = P1;
        step();
        bus.net_si = 1'b0;
        checkOutput("in_ri_low", 64'(bus.net_ri), 64'd0);
        peek("in_stat_full", 2'b01, ST_FULL);
        applyStimulus(2'b00, 1'b1, 1'b0, 64'h0);
        #1;
        checkOutput("in_read_pkt", bus.d_out, P1);
        step();
        checkOutput("in_ri_back", 64'(bus.net_ri), 64'd1);
        peek("in_stat_empty", 2'b01, 64'h0);

        // Drain and router offer in the same cycle: router refused
        bus.net_si = 1'b1;
        bus.net_di = P2;
        step();
        applyStimulus(2'b00, 1'b1, 1'b0, 64'h0);
        bus.net_di = P3;
        #1;
        checkOutput("refuse_ri", 64'(bus.net_ri), 64'd0);
        checkOutput("refuse_read", bus.d_out, P2);
        step();
        bus.net_si = 1'b0;
        #1;
        checkOutput("refuse_ri_after", 64'(bus.net_ri), 64'd1);
        peek("refuse_stale", 2'b00, P2);

        // Polarity gating on the output channel
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        applyStimulus(2'b10, 1'b1, 1'b1, P4);
        step();
        peek("pol_stat_full", 2'b11, ST_FULL);
        checkOutput("pol_so_even", 64'(bus.net_so), 64'd0);
        checkOutput("pol_do", bus.net_do, P4);
        peek("pol_read10", 2'b10, 64'h0);
        step();
        checkOutput("pol_so_even2", 64'(bus.net_so), 64'd0);
        bus.net_polarity = 1'b1;
        #1;
        checkOutput("pol_so_odd", 64'(bus.net_so), 64'd1);
        step();
        checkOutput("pol_so_done", 64'(bus.net_so), 64'd0);
        peek("pol_stat_empty", 2'b11, 64'h0);
        bus.net_polarity = 1'b0;

        // Back-pressure: write into a full output buffer is dropped
        bus.net_ro = 1'b0;
        applyStimulus(2'b10, 1'b1, 1'b1, P5);
        step();
        peek("bp_stat_full", 2'b11, ST_FULL);
        applyStimulus(2'b10, 1'b1, 1'b1, 64'hFFFF);
        step();
        checkOutput("bp_do_kept", bus.net_do, P5);
        peek("bp_stat_err", 2'b11, ST_FULL | ST_ERR);
        applyStimulus(2'b11, 1'b1, 1'b0, 64'h0);
        step();
        peek("bp_stat_clr", 2'b11, ST_FULL);

        // No bypass: drain and write in the same cycle, write still dropped
        bus.net_ro = 1'b1;
        applyStimulus(2'b10, 1'b1, 1'b1, P6);
        #1;
        checkOutput("nb_so", 64'(bus.net_so), 64'd1);
        step();
        bus.net_ro = 1'b0;
        checkOutput("nb_do", bus.net_do, P5);
        peek("nb_stat", 2'b11, ST_ERR);
        applyStimulus(2'b11, 1'b1, 1'b0, 64'h0);
        step();
        peek("nb_stat_clr", 2'b11, 64'h0);

        // Empty read of the input buffer, and an ignored write to it
        applyStimulus(2'b00, 1'b1, 1'b0, 64'h0);
        #1;
        checkOutput("er_stale", bus.d_out, P2);
        step();
        checkOutput("er_ri", 64'(bus.net_ri), 64'd1);
        applyStimulus(2'b01, 1'b1, 1'b0, 64'h0);
        #1;
        checkOutput("er_stat_first", bus.d_out, ST_ERR);
        step();
        peek("er_stat_second", 2'b01, 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b1, 64'hDEAD);
        step();
        peek("wr00_ignored", 2'b00, P2);
        peek("wr00_stat", 2'b01, 64'h0);

        // Concurrent traffic on both channels
        bus.net_si = 1'b1;
        bus.net_di = P7;
        applyStimulus(2'b10, 1'b1, 1'b1, P8);
        step();
        bus.net_si = 1'b0;
        peek("cc_in_stat", 2'b01, ST_FULL);
        peek("cc_out_stat", 2'b11, ST_FULL);
        checkOutput("cc_do", bus.net_do, P8);
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        applyStimulus(2'b00, 1'b1, 1'b0, 64'h0);
        #1;
        checkOutput("cc_read", bus.d_out, P7);
        checkOutput("cc_so", 64'(bus.net_so), 64'd1);
        step();
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        peek("cc_in_empty", 2'b01, 64'h0);
        peek("cc_out_empty", 2'b11, 64'h0);

        // Asynchronous reset mid-cycle with both buffers full
        bus.net_si = 1'b1;
        bus.net_di = P1;
        applyStimulus(2'b10, 1'b1, 1'b1, P4);
        step();
        bus.net_si       = 1'b0;
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        #1;
        checkOutput("pre_rst_so", 64'(bus.net_so), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ri", 64'(bus.net_ri), 64'd1);
        checkOutput("mid_rst_so", 64'(bus.net_so), 64'd0);
        checkOutput("mid_rst_do", bus.net_do, 64'h0);
        for (int a = 0; a < 4; a++) begin
            peek($sformatf("mid_rst_dout%0d", a), 2'(a), 64'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
